ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
- Execute stage plus EX/MEM pipeline register for the 5-stage MIPS core.
- Sits directly downstream of the ID/EX register and consumes its outputs: WB/M controls, ALUSrc, ALUOp, RegDst, read data 1/2, the sign-extended immediate, and rs/rt/rd.
- Performs operand forwarding and ALU evaluation, then latches the results for the MEM stage.
- Contains an iterative 32-cycle shift-add multiplier; it raises stall_o to freeze PC, IF/ID and ID/EX while busy.

Parameters:
- MUL_CYCLES, 32, number of multiplier iterations (one per operand bit).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- wb_i  in  2  [1]=RegWrite, [0]=MemtoReg.
- m_i  in  2  [1]=MemRead, [0]=MemWrite.
- alusrc_i  in  1  1 selects immediate as operand B.
- aluop_i  in  2  ALU operation class.
- regdst_i  in  1  1 selects rd as destination, 0 selects rt.
- data1_i  in  32  rs read data.
- data2_i  in  32  rt read data.
- imm_i  in  32  sign-extended immediate; [5:0] is funct.
- rs_i  in  5  rs index.
- rt_i  in  5  rt index.
- rd_i  in  5  rd index.
- wb_regwrite_i  in  1  MEM/WB RegWrite.
- wb_rd_i  in  5  MEM/WB destination.
- wb_data_i  in  32  MEM/WB write-back value.
- wb_o  out  2  registered WB controls.
- m_o  out  2  registered M controls.
- alu_result_o  out  32  registered ALU or multiplier result.
- write_data_o  out  32  registered forwarded rt value (store data).
- write_reg_o  out  5  registered destination index.
- stall_o  out  1  combinational; upstream holds while high.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, multiplier registers and counter 0. Reset is asynchronous and takes effect even in the middle of a multiply.
- Forwarding for operand A (rs) and the rt value, evaluated independently:
  - EX/MEM first: if wb_o[1] and write_reg_o != 0 and write_reg_o == index, use alu_result_o.
  - Else MEM/WB: if wb_regwrite_i and wb_rd_i != 0 and wb_rd_i == index, use wb_data_i.
  - Else use the register-file value.
  - Register 0 is never forwarded.
- Operand B = alusrc_i ? imm_i : forwarded rt value.
- ALU operation:
  - aluop 00 → add.
  - aluop 01 → sub.
  - aluop 11 → add.
  - aluop 10 → decode funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x18 mul. Any other funct gives result 0.
  - Arithmetic is 32-bit wrap-around with no overflow detection.
- Destination = regdst_i ? rd_i : rt_i.
- Non-mul instruction: 1-cycle latency. The register captures wb_i, m_i, the result, the forwarded rt value and the destination at the next posedge. stall_o = 0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE with mul decoded:
    - stall_o = 1.
    - Latch the forwarded operands A and B; counter = 0; product = 0.
    - Go to BUSY.
    - EX/MEM loads a bubble: wb_o = 0, m_o = 0, other outputs hold.
  - BUSY:
    - stall_o = 1.
    - Each cycle, if multiplier bit 0 is set, add the multiplicand to the product; shift the multiplicand left and the multiplier right; counter + 1.
    - When counter == MUL_CYCLES-1, go to DONE.
    - EX/MEM loads a bubble every cycle.
  - DONE:
    - stall_o = 0.
    - EX/MEM captures wb_i, m_i, the low 32 bits of the product, and the destination.
    - Go to IDLE.
    - The same mul is still present on the inputs this cycle and must not restart.
- Mul timing: 34 cycles in EX in total (IDLE + 32 BUSY + DONE); stall_o is high for 33 consecutive cycles.
- Operands are latched once, so EX/MEM or MEM/WB changes during BUSY do not affect the product.
- A mul arriving in IDLE on the cycle immediately after DONE starts normally.

Optional Feature:
- Macro: MULT_UNIT_EN.
- Defined: multiplier and FSM present, behaving as above.
- Undefined: no FSM or multiplier; funct 0x18 gives result 0 with 1-cycle latency; stall_o is tied to 0.

Test Plan:
- Reset: assert rst mid-BUSY → all outputs 0 and stall_o 0 immediately; a later mul restarts from IDLE.
- add: aluop 10, funct 0x20, data1 = 7, data2 = 5, rd = 3 → next cycle alu_result_o = 12, write_reg_o = 3, wb_o = wb_i.
- Forwarding priority: previous instruction wrote r4 = 100 (still in EX/MEM); MEM/WB also writes r4 = 55; sub with rs = 4, rt = 0 → alu_result_o = 100. Repeat with rd = 0 → no forwarding.
- lw address: aluop 00, alusrc 1, data1 = 0x1000, imm = 0xFFFFFFFC → 0x0FFC; regdst 0 → write_reg_o = rt; m_o = 2'b10.
- mul: data1 = 0xFFFFFFFF (-1), data2 = 6 → stall_o high 33 cycles, wb_o = 0 throughout; then alu_result_o = 0xFFFFFFFA, wb_o restored.
- Back-to-back mul 3×4 then 5×5 → results 12 and 25, each with a full 33-cycle stall, no spurious restart.

Source files
------------

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX stage (forwarding, ALU) plus EX/MEM pipeline register
// Defining MULT_UNIT_EN adds the iterative shift-add multiplier and its stall FSM.
module ex_mem_stage #(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  wb_i,
  input  logic [1:0]  m_i,
  input  logic        alusrc_i,
  input  logic [1:0]  aluop_i,
  input  logic        regdst_i,
  input  logic [31:0] data1_i,
  input  logic [31:0] data2_i,
  input  logic [31:0] imm_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic        wb_regwrite_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_data_i,
  output logic [1:0]  wb_o,
  output logic [1:0]  m_o,
  output logic [31:0] alu_result_o,
  output logic [31:0] write_data_o,
  output logic [4:0]  write_reg_o,
  output logic        stall_o
);
  logic [1:0]  wb_q, wb_d, m_q, m_d;
  logic [31:0] alu_result_q, alu_result_d, write_data_q, write_data_d;
  logic [4:0]  write_reg_q, write_reg_d;
  logic [31:0] op_a, rt_fwd, op_b, alu_val;
  logic [4:0]  dest;
  logic        stall;

  // EX/MEM result wins over MEM/WB because it is the younger producer.
  always_comb begin
    if (wb_q[1] && write_reg_q != 5'd0 && write_reg_q == rs_i) op_a = alu_result_q;
    else if (wb_regwrite_i && wb_rd_i != 5'd0 && wb_rd_i == rs_i) op_a = wb_data_i;
    else op_a = data1_i;
    if (wb_q[1] && write_reg_q != 5'd0 && write_reg_q == rt_i) rt_fwd = alu_result_q;
    else if (wb_regwrite_i && wb_rd_i != 5'd0 && wb_rd_i == rt_i) rt_fwd = wb_data_i;
    else rt_fwd = data2_i;
  end

  assign op_b = alusrc_i ? imm_i : rt_fwd;
  assign dest = regdst_i ? rd_i : rt_i;

  always_comb begin
    alu_val = '0;
    case (aluop_i)
      2'b01: alu_val = op_a - op_b;
      2'b10: begin
        case (imm_i[5:0])
          6'h20:   alu_val = op_a + op_b;
          6'h22:   alu_val = op_a - op_b;
          6'h24:   alu_val = op_a & op_b;
          6'h25:   alu_val = op_a | op_b;
          default: alu_val = '0;
        endcase
      end
      default: alu_val = op_a + op_b;
    endcase
  end

`ifdef MULT_UNIT_EN
  localparam int CW = $clog2(MUL_CYCLES) + 1;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [31:0]   mcand_q, mcand_d, mplier_q, mplier_d, prod_q, prod_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_mul;

  assign is_mul = (aluop_i == 2'b10) && (imm_i[5:0] == 6'h18);
`endif

  always_comb begin
    wb_d         = wb_i;
    m_d          = m_i;
    alu_result_d = alu_val;
    write_data_d = rt_fwd;
    write_reg_d  = dest;
    stall        = 1'b0;
`ifdef MULT_UNIT_EN
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    // Bubble: kill controls, keep data so nothing downstream toggles needlessly.
    if ((state_q == ST_IDLE && is_mul) || state_q == ST_BUSY) begin
      wb_d         = 2'b00;
      m_d          = 2'b00;
      alu_result_d = alu_result_q;
      write_data_d = write_data_q;
      write_reg_d  = write_reg_q;
      stall        = 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (is_mul) begin
          mcand_d  = op_a;
          mplier_d = op_b;
          prod_d   = '0;
          cnt_d    = '0;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(MUL_CYCLES - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        // The mul is still on the inputs here; returning to IDLE unconditionally prevents a restart.
        alu_result_d = prod_q;
        write_data_d = write_data_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q         <= '0;
      m_q          <= '0;
      alu_result_q <= '0;
      write_data_q <= '0;
      write_reg_q  <= '0;
`ifdef MULT_UNIT_EN
      state_q      <= ST_IDLE;
      mcand_q      <= '0;
      mplier_q     <= '0;
      prod_q       <= '0;
      cnt_q        <= '0;
`endif
    end else begin
      wb_q         <= wb_d;
      m_q          <= m_d;
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      write_reg_q  <= write_reg_d;
`ifdef MULT_UNIT_EN
      state_q      <= state_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      prod_q       <= prod_d;
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign wb_o         = wb_q;
  assign m_o          = m_q;
  assign alu_result_o = alu_result_q;
  assign write_data_o = write_data_q;
  assign write_reg_o  = write_reg_q;
  assign stall_o      = stall & ~rst;
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - self-checking bench for ex_mem_stage
// Expectations follow MULT_UNIT_EN: with it, mul stalls 33 cycles; without it, funct 0x18 gives 0.
module tb_ex_mem_stage;
`ifdef MULT_UNIT_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wb_i, m_i, aluop_i;
  logic        alusrc_i, regdst_i;
  logic [31:0] data1_i, data2_i, imm_i;
  logic [4:0]  rs_i, rt_i, rd_i;
  logic        wb_regwrite_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  logic [1:0]  wb_o, m_o;
  logic [31:0] alu_result_o, write_data_o;
  logic [4:0]  write_reg_o;
  logic        stall_o;

  int n_cmp = 0;
  int n_err = 0;

  ex_mem_stage dut (
    .clk(clk), .rst(rst), .wb_i(wb_i), .m_i(m_i), .alusrc_i(alusrc_i),
    .aluop_i(aluop_i), .regdst_i(regdst_i), .data1_i(data1_i), .data2_i(data2_i),
    .imm_i(imm_i), .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i),
    .wb_regwrite_i(wb_regwrite_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
    .wb_o(wb_o), .m_o(m_o), .alu_result_o(alu_result_o), .write_data_o(write_data_o),
    .write_reg_o(write_reg_o), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [1:0] wb, input logic [1:0] m, input logic src,
                       input logic [1:0] op, input logic dst, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] imm,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    wb_i = wb; m_i = m; alusrc_i = src; aluop_i = op; regdst_i = dst;
    data1_i = d1; data2_i = d2; imm_i = imm; rs_i = rs; rt_i = rt; rd_i = rd;
  endtask

  task automatic memwb(input logic we, input logic [4:0] rd, input logic [31:0] d);
    wb_regwrite_i = we; wb_rd_i = rd; wb_data_i = d;
  endtask

  function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [5:0] fn,
                                          input logic [31:0] a, input logic [31:0] b);
    if (op == 2'b01) return a - b;
    if (op != 2'b10) return a + b;
    if (fn == 6'h20) return a + b;
    if (fn == 6'h22) return a - b;
    if (fn == 6'h24) return a & b;
    if (fn == 6'h25) return a | b;
    if (fn == 6'h18 && MUL_EN) return a * b;
    return 32'd0;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    issue(2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 0, 0, 0, 0, 0, 0);
    memwb(1'b0, 5'd0, 32'd0);
    @(posedge clk); #1;
    n_cmp++; if (wb_o !== 2'b00) begin n_err++; $display("FAIL reset_wb: got %b want 00", wb_o); end
    n_cmp++; if (m_o !== 2'b00) begin n_err++; $display("FAIL reset_m: got %b want 00", m_o); end
    n_cmp++; if (alu_result_o !== 32'd0) begin n_err++; $display("FAIL reset_result: got %h want 0", alu_result_o); end
    n_cmp++; if (write_reg_o !== 5'd0) begin n_err++; $display("FAIL reset_reg: got %0d want 0", write_reg_o); end
    n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall_o); end
    rst = 1'b0;
    issue(2'b11, 2'b01, 1'b1, 2'b00, 1'b1, 32'd40, 32'd9, 32'd2, 5'd1, 5'd2, 5'd7);
    @(posedge clk); #1;
    n_cmp++; if (alu_result_o !== 32'd42) begin n_err++; $display("FAIL pre_async_result: got %h want 2a", alu_result_o); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (alu_result_o !== 32'd0 || wb_o !== 2'b00 || m_o !== 2'b00 || write_reg_o !== 5'd0 || write_data_o !== 32'd0)
      begin n_err++; $display("FAIL async_reset: got wb=%b m=%b res=%h wd=%h reg=%0d want all 0", wb_o, m_o, alu_result_o, write_data_o, write_reg_o); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_add;
    issue(2'b10, 2'b00, 1'b0, 2'b10, 1'b1, 32'd7, 32'd5, 32'h20, 5'd1, 5'd2, 5'd3);
    #1;
    n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL add_stall: got %b want 0", stall_o); end
    @(posedge clk); #1;
    n_cmp++; if (alu_result_o !== 32'd12) begin n_err++; $display("FAIL add_result: got %h want c", alu_result_o); end
    n_cmp++; if (write_reg_o !== 5'd3) begin n_err++; $display("FAIL add_reg: got %0d want 3", write_reg_o); end
    n_cmp++; if (wb_o !== 2'b10) begin n_err++; $display("FAIL add_wb: got %b want 10", wb_o); end
    n_cmp++; if (write_data_o !== 32'd5) begin n_err++; $display("FAIL add_wdata: got %h want 5", write_data_o); end
  endtask

  task automatic test_forwarding;
    memwb(1'b0, 5'd0, 32'd0);
    issue(2'b10, 2'b00, 1'b1, 2'b00, 1'b0, 32'd100, 32'd0, 32'd0, 5'd1, 5'd4, 5'd0);
    @(posedge clk); #1;
    // r4 = 100 sits in EX/MEM, MEM/WB also writes r4 = 55: the younger value must win
    issue(2'b10, 2'b00, 1'b0, 2'b01, 1'b0, 32'd999, 32'd0, 32'd0, 5'd4, 5'd0, 5'd0);
    memwb(1'b1, 5'd4, 32'd55);
    @(posedge clk); #1;
    n_cmp++; if (alu_result_o !== 32'd100) begin n_err++; $display("FAIL fwd_exmem: got %0d want 100", alu_result_o); end
    // EX/MEM now targets r0 with value 100; neither r0 producer may forward
    issue(2'b10, 2'b00, 1'b0, 2'b01, 1'b0, 32'd7, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    memwb(1'b1, 5'd0, 32'd55);
    @(posedge clk); #1;
    n_cmp++; if (alu_result_o !== 32'd7) begin n_err++; $display("FAIL fwd_r0: got %0d want 7", alu_result_o); end
    issue(2'b10, 2'b00, 1'b0, 2'b01, 1'b0, 32'd999, 32'd3, 32'd0, 5'd4, 5'd5, 5'd0);
    memwb(1'b1, 5'd4, 32'd55);
    @(posedge clk); #1;
    n_cmp++; if (alu_result_o !== 32'd52) begin n_err++; $display("FAIL fwd_memwb: got %0d want 52", alu_result_o); end
    memwb(1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_lw;
    issue(2'b11, 2'b10, 1'b1, 2'b00, 1'b0, 32'h1000, 32'hABCD, 32'hFFFF_FFFC, 5'd1, 5'd9, 5'd3);
    @(posedge clk); #1;
    n_cmp++; if (alu_result_o !== 32'h0FFC) begin n_err++; $display("FAIL lw_addr: got %h want 00000ffc", alu_result_o); end
    n_cmp++; if (write_reg_o !== 5'd9) begin n_err++; $display("FAIL lw_reg: got %0d want 9", write_reg_o); end
    n_cmp++; if (m_o !== 2'b10) begin n_err++; $display("FAIL lw_m: got %b want 10", m_o); end
    n_cmp++; if (wb_o !== 2'b11) begin n_err++; $display("FAIL lw_wb: got %b want 11", wb_o); end
  endtask

  task automatic test_random;
    logic [5:0]  fl[6];
    logic [1:0]  e_wb, e_m;
    logic [4:0]  e_reg;
    logic [31:0] e_res, e_wd, a, rtv, b;
    logic [5:0]  fn;
    fl[0] = 6'h20; fl[1] = 6'h22; fl[2] = 6'h24; fl[3] = 6'h25; fl[4] = 6'h18; fl[5] = 6'h3F;
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    e_wb = 0; e_m = 0; e_reg = 0; e_res = 0; e_wd = 0;
    for (int i = 0; i < 200; i++) begin
      fn = fl[$urandom_range(5, 0)];
      if (MUL_EN && fn == 6'h18) fn = 6'h20;
      issue(2'($urandom), 2'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
            $urandom, $urandom, {$urandom} & 32'hFFFF_FFC0 | {26'd0, fn},
            5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)));
      memwb(1'($urandom), 5'($urandom_range(7, 0)), $urandom);
      #1;
      a   = (e_wb[1] && e_reg != 0 && e_reg == rs_i) ? e_res :
            (wb_regwrite_i && wb_rd_i != 0 && wb_rd_i == rs_i) ? wb_data_i : data1_i;
      rtv = (e_wb[1] && e_reg != 0 && e_reg == rt_i) ? e_res :
            (wb_regwrite_i && wb_rd_i != 0 && wb_rd_i == rt_i) ? wb_data_i : data2_i;
      b = alusrc_i ? imm_i : rtv;
      e_res = ref_alu(aluop_i, fn, a, b);
      e_wd = rtv; e_wb = wb_i; e_m = m_i; e_reg = regdst_i ? rd_i : rt_i;
      n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL rnd%0d_stall: got %b want 0", i, stall_o); end
      @(posedge clk); #1;
      n_cmp++; if (alu_result_o !== e_res) begin n_err++; $display("FAIL rnd%0d_result: got %h want %h", i, alu_result_o, e_res); end
      n_cmp++; if (write_data_o !== e_wd) begin n_err++; $display("FAIL rnd%0d_wdata: got %h want %h", i, write_data_o, e_wd); end
      n_cmp++; if (write_reg_o !== e_reg) begin n_err++; $display("FAIL rnd%0d_reg: got %0d want %0d", i, write_reg_o, e_reg); end
      n_cmp++; if (wb_o !== e_wb || m_o !== e_m) begin n_err++; $display("FAIL rnd%0d_ctl: got wb=%b m=%b want wb=%b m=%b", i, wb_o, m_o, e_wb, e_m); end
    end
    memwb(1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_mul;
    int scnt, bub;
    issue(2'b10, 2'b00, 1'b0, 2'b10, 1'b1, 32'hFFFF_FFFF, 32'd6, 32'h18, 5'd10, 5'd11, 5'd5);
    scnt = 0; bub = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!stall_o) break;
      scnt++;
      if (c == 5) memwb(1'b1, 5'd10, 32'd123);
      @(posedge clk); #1;
      if (wb_o !== 2'b00 || m_o !== 2'b00) bub++;
    end
    @(posedge clk); #1;
    memwb(1'b0, 5'd0, 32'd0);
    n_cmp++; if (scnt !== (MUL_EN ? 33 : 0)) begin n_err++; $display("FAIL mul_stall_len: got %0d want %0d", scnt, MUL_EN ? 33 : 0); end
    n_cmp++; if (bub !== 0) begin n_err++; $display("FAIL mul_bubble: got %0d non-bubble cycles want 0", bub); end
    n_cmp++; if (alu_result_o !== (MUL_EN ? 32'hFFFF_FFFA : 32'd0)) begin n_err++; $display("FAIL mul_result: got %h want %h", alu_result_o, MUL_EN ? 32'hFFFF_FFFA : 32'd0); end
    n_cmp++; if (wb_o !== 2'b10 || write_reg_o !== 5'd5) begin n_err++; $display("FAIL mul_ctl: got wb=%b reg=%0d want wb=10 reg=5", wb_o, write_reg_o); end
  endtask

  task automatic test_back_to_back;
    int scnt, bub;
    logic [31:0] ea[2], eb[2];
    logic [4:0]  erd[2];
    ea[0] = 32'd3; eb[0] = 32'd4; erd[0] = 5'd12;
    ea[1] = 32'd5; eb[1] = 32'd5; erd[1] = 5'd15;
    for (int k = 0; k < 2; k++) begin
      issue(2'b10, 2'b00, 1'b0, 2'b10, 1'b1, ea[k], eb[k], 32'h18, 5'd13, 5'd14, erd[k]);
      scnt = 0; bub = 0;
      for (int c = 0; c < 40; c++) begin
        #1;
        if (!stall_o) break;
        scnt++;
        @(posedge clk); #1;
        if (wb_o !== 2'b00) bub++;
      end
      @(posedge clk); #1;
      n_cmp++; if (scnt !== (MUL_EN ? 33 : 0)) begin n_err++; $display("FAIL b2b%0d_stall_len: got %0d want %0d", k, scnt, MUL_EN ? 33 : 0); end
      n_cmp++; if (bub !== 0) begin n_err++; $display("FAIL b2b%0d_bubble: got %0d want 0", k, bub); end
      n_cmp++; if (alu_result_o !== (MUL_EN ? ea[k] * eb[k] : 32'd0)) begin n_err++; $display("FAIL b2b%0d_result: got %0d want %0d", k, alu_result_o, MUL_EN ? ea[k] * eb[k] : 32'd0); end
    end
    issue(2'b10, 2'b00, 1'b0, 2'b00, 1'b1, 32'd1, 32'd2, 32'd0, 5'd20, 5'd21, 5'd22);
    #1;
    n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL b2b_restart: got stall %b want 0", stall_o); end
    @(posedge clk); #1;
    n_cmp++; if (alu_result_o !== 32'd3) begin n_err++; $display("FAIL b2b_after_add: got %0d want 3", alu_result_o); end
  endtask

  task automatic test_reset_mid_mul;
    int scnt;
    issue(2'b10, 2'b00, 1'b0, 2'b10, 1'b1, 32'd7, 32'd9, 32'h18, 5'd16, 5'd17, 5'd18);
    repeat (10) @(posedge clk);
    #3;
    n_cmp++; if (stall_o !== MUL_EN) begin n_err++; $display("FAIL midmul_busy: got stall %b want %b", stall_o, MUL_EN); end
    rst = 1'b1;
    #1;
    n_cmp++; if (stall_o !== 1'b0 || wb_o !== 2'b00 || alu_result_o !== 32'd0 || write_reg_o !== 5'd0)
      begin n_err++; $display("FAIL midmul_reset: got stall=%b wb=%b res=%h reg=%0d want all 0", stall_o, wb_o, alu_result_o, write_reg_o); end
    @(posedge clk); #1;
    rst = 1'b0;
    scnt = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!stall_o) break;
      scnt++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    n_cmp++; if (scnt !== (MUL_EN ? 33 : 0)) begin n_err++; $display("FAIL midmul_restart_len: got %0d want %0d", scnt, MUL_EN ? 33 : 0); end
    n_cmp++; if (alu_result_o !== (MUL_EN ? 32'd63 : 32'd0)) begin n_err++; $display("FAIL midmul_result: got %0d want %0d", alu_result_o, MUL_EN ? 32'd63 : 32'd0); end
  endtask

  initial begin
    test_reset;
    test_add;
    test_forwarding;
    test_lw;
    test_random;
    test_mul;
    test_back_to_back;
    test_reset_mid_mul;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
